// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and state encoding for the fetch stage
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DROP  = 2'd2
    } fetch_state_t;

    // Wraps naturally at 32 bits: 0xFFFFFFFC -> 0x00000000.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// rtl/fetch_stage_if_id_reg.sv - IF/ID pipeline register with load, bubble and hold
module if_id_reg
    import fetch_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        bubble_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        valid_o
);

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic        r_valid;

    // Load has priority over bubble; a bubble keeps the last PC for debug visibility.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_pc    <= RESET_PC;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (load_i) begin
            r_pc    <= pc_i;
            r_instr <= instr_i;
            r_valid <= 1'b1;
        end else if (bubble_i) begin
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end
    end

    assign pc_o    = r_pc;
    assign instr_o = r_instr;
    assign valid_o = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch FSM, fetch PC and redirect handling
module fetch_stage
    import fetch_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pc_write_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] branch_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        valid_o
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_fetch_pc;
    logic [31:0]  w_fetch_pc_next;
    logic [31:0]  r_buf;
    logic [31:0]  r_target;
    logic         w_buf_we;
    logic         w_tgt_we;
    logic         w_load;
    logic         w_bubble;
    logic [31:0]  w_load_instr;
    logic         w_hold;
    logic         w_flush;

    assign w_hold  = stall_i | ~pc_write_i;
    assign w_flush = flush_i & ~w_hold;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_FETCH;
            r_fetch_pc <= RESET_PC;
            r_buf      <= NOP_INSTR;
            r_target   <= RESET_PC;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
            if (w_buf_we) r_buf <= imem_rdata_i;
            if (w_tgt_we) r_target <= branch_target_i;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        w_buf_we        = 1'b0;
        w_tgt_we        = 1'b0;
        w_load          = 1'b0;
        w_bubble        = 1'b0;
        w_load_instr    = imem_rdata_i;
        case (r_state)
            S_FETCH: begin
                if (imem_ready_i) begin
                    if (w_hold) begin
                        w_buf_we     = 1'b1;
                        w_state_next = S_HOLD;
                    end else if (w_flush) begin
                        w_bubble        = 1'b1;
                        w_fetch_pc_next = branch_target_i;
                    end else begin
                        w_load          = 1'b1;
                        w_fetch_pc_next = next_pc(r_fetch_pc);
                    end
                end else if (!w_hold) begin
                    // The request is still in flight, so a redirect must wait for it in S_DROP.
                    w_bubble = 1'b1;
                    if (w_flush) begin
                        w_tgt_we     = 1'b1;
                        w_state_next = S_DROP;
                    end
                end
            end
            S_HOLD: begin
                w_load_instr = r_buf;
                if (!w_hold) begin
                    w_state_next = S_FETCH;
                    if (w_flush) begin
                        w_bubble        = 1'b1;
                        w_fetch_pc_next = branch_target_i;
                    end else begin
                        w_load          = 1'b1;
                        w_fetch_pc_next = next_pc(r_fetch_pc);
                    end
                end
            end
            S_DROP: begin
                if (w_flush) w_tgt_we = 1'b1;
                if (imem_ready_i) begin
                    w_fetch_pc_next = w_flush ? branch_target_i : r_target;
                    w_state_next    = S_FETCH;
                end
            end
            default: begin
                w_state_next = S_FETCH;
            end
        endcase
    end

    assign imem_req_o  = ~rst_i & (r_state != S_HOLD);
    assign imem_addr_o = r_fetch_pc;

    if_id_reg u_if_id_reg (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (w_load),
        .bubble_i (w_bubble),
        .pc_i     (r_fetch_pc),
        .instr_i  (w_load_instr),
        .pc_o     (pc_o),
        .instr_o  (instr_o),
        .valid_o  (valid_o)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_write;
    logic        stall;
    logic        flush;
    logic [31:0] target;
    logic        req;
    logic [31:0] addr;
    logic        ready;
    logic [31:0] rdata;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    // Memory model: each word holds its own address plus 0x100.
    assign rdata = addr + 32'h100;

    fetch_stage dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .pc_write_i      (pc_write),
        .stall_i         (stall),
        .flush_i         (flush),
        .branch_target_i (target),
        .imem_req_o      (req),
        .imem_addr_o     (addr),
        .imem_ready_i    (ready),
        .imem_rdata_i    (rdata),
        .pc_o            (pc),
        .instr_o         (instr),
        .valid_o         (valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; pc_write = 1'b1; stall = 1'b0; flush = 1'b0;
        target = 32'h0; ready = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pc_write = 1'b1; stall = 1'b0; flush = 1'b0;
        target = 32'hDEAD_BEEC; ready = 1'b1;
        tick();
        tick();
        n_total++;
        if ({req, pc, instr, valid} !== {1'b0, 32'h0, 32'h13, 1'b0})
            $display("FAIL reset_state: req=%0b pc=%h instr=%h valid=%0b, need 0/0/13/0", req, pc, instr, valid);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_total++;
        if ({req, addr} !== {1'b1, 32'h0})
            $display("FAIL reset_first_req: req=%0b addr=%h, need 1/0", req, addr);
        else n_pass++;
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            n_total++;
            if ({pc, instr, valid} !== {32'(4 * i), 32'(32'h100 + 4 * i), 1'b1})
                $display("FAIL stream_%0d: pc=%h instr=%h valid=%0b, need %h/%h/1", i, pc, instr, valid, 4 * i, 32'h100 + 4 * i);
            else n_pass++;
        end
        ready = 1'b0;
        tick();
        n_total++;
        if ({pc, instr, valid, addr} !== {32'hC, 32'h13, 1'b0, 32'h10})
            $display("FAIL stream_bubble: pc=%h instr=%h valid=%0b addr=%h, need c/13/0/10", pc, instr, valid, addr);
        else n_pass++;
    endtask

    task automatic test_hold();
        do_reset();
        tick();
        tick();
        stall = 1'b1; pc_write = 1'b0;
        tick();
        tick();
        n_total++;
        if ({pc, valid, req, addr} !== {32'h4, 1'b1, 1'b0, 32'h8})
            $display("FAIL hold_held: pc=%h valid=%0b req=%0b addr=%h, need 4/1/0/8", pc, valid, req, addr);
        else n_pass++;
        stall = 1'b0; pc_write = 1'b1;
        tick();
        n_total++;
        if ({pc, instr, valid, req, addr} !== {32'h8, 32'h108, 1'b1, 1'b1, 32'hC})
            $display("FAIL hold_release: pc=%h instr=%h valid=%0b req=%0b addr=%h, need 8/108/1/1/c", pc, instr, valid, req, addr);
        else n_pass++;
    endtask

    task automatic test_flush_ready();
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        flush = 1'b1; target = 32'h40;
        tick();
        flush = 1'b0;
        n_total++;
        if ({pc, instr, valid, addr} !== {32'hC, 32'h13, 1'b0, 32'h40})
            $display("FAIL flush_ready_bubble: pc=%h instr=%h valid=%0b addr=%h, need c/13/0/40", pc, instr, valid, addr);
        else n_pass++;
        tick();
        n_total++;
        if ({pc, instr, valid} !== {32'h40, 32'h140, 1'b1})
            $display("FAIL flush_ready_target: pc=%h instr=%h valid=%0b, need 40/140/1", pc, instr, valid);
        else n_pass++;
        flush = 1'b1; target = 32'hFFFF_FFFC;
        tick();
        flush = 1'b0;
        tick();
        n_total++;
        if ({pc, instr, addr} !== {32'hFFFF_FFFC, 32'h0000_00FC, 32'h0})
            $display("FAIL pc_wrap: pc=%h instr=%h addr=%h, need fffffffc/fc/0", pc, instr, addr);
        else n_pass++;
    endtask

    task automatic test_flush_noready();
        do_reset();
        tick();
        ready = 1'b0; flush = 1'b1; target = 32'h80;
        tick();
        flush = 1'b0; target = 32'h0;
        n_total++;
        if ({valid, instr, req, addr} !== {1'b0, 32'h13, 1'b1, 32'h4})
            $display("FAIL drop_enter: valid=%0b instr=%h req=%0b addr=%h, need 0/13/1/4", valid, instr, req, addr);
        else n_pass++;
        tick();
        tick();
        n_total++;
        if ({valid, req, addr} !== {1'b0, 1'b1, 32'h4})
            $display("FAIL drop_wait: valid=%0b req=%0b addr=%h, need 0/1/4", valid, req, addr);
        else n_pass++;
        ready = 1'b1;
        tick();
        n_total++;
        if ({valid, addr} !== {1'b0, 32'h80})
            $display("FAIL drop_discard: valid=%0b addr=%h, need 0/80", valid, addr);
        else n_pass++;
        tick();
        n_total++;
        if ({pc, instr, valid} !== {32'h80, 32'h180, 1'b1})
            $display("FAIL drop_target: pc=%h instr=%h valid=%0b, need 80/180/1", pc, instr, valid);
        else n_pass++;
    endtask

    task automatic test_flush_stall();
        do_reset();
        tick();
        flush = 1'b1; stall = 1'b1; target = 32'h40;
        tick();
        flush = 1'b0; stall = 1'b0;
        n_total++;
        if ({pc, valid, req, addr} !== {32'h0, 1'b1, 1'b0, 32'h4})
            $display("FAIL flush_stall_held: pc=%h valid=%0b req=%0b addr=%h, need 0/1/0/4", pc, valid, req, addr);
        else n_pass++;
        tick();
        n_total++;
        if ({pc, instr, addr} !== {32'h4, 32'h104, 32'h8})
            $display("FAIL flush_stall_resume: pc=%h instr=%h addr=%h, need 4/104/8", pc, instr, addr);
        else n_pass++;
    endtask

    task automatic test_reset_drop();
        do_reset();
        ready = 1'b0; flush = 1'b1; target = 32'h80;
        tick();
        flush = 1'b0; rst = 1'b1; ready = 1'b1;
        tick();
        n_total++;
        if ({req, pc, instr, valid} !== {1'b0, 32'h0, 32'h13, 1'b0})
            $display("FAIL reset_drop_state: req=%0b pc=%h instr=%h valid=%0b, need 0/0/13/0", req, pc, instr, valid);
        else n_pass++;
        rst = 1'b0;
        #1;
        tick();
        n_total++;
        if ({pc, instr, valid, addr} !== {32'h0, 32'h100, 1'b1, 32'h4})
            $display("FAIL reset_drop_restart: pc=%h instr=%h valid=%0b addr=%h, need 0/100/1/4", pc, instr, valid, addr);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_hold();
        test_flush_ready();
        test_flush_noready();
        test_flush_stall();
        test_reset_drop();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1);
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high: clk_i input 1 (all state on rising edge), rst_i input 1 (sync active-high reset).
REQ-002 SHALL have pc_write_i  input  1  PC update enable from hazard detection, 0 = hold PC.
REQ-003 SHALL have stall_i  input  1  IF/ID hold request from hazard detection.
REQ-004 SHALL have flush_i  input  1  branch taken in ID; squash IF/ID and redirect.
REQ-005 SHALL have branch_target_i  input  32  redirect PC, sampled when flush accepted.
REQ-006 SHALL have imem_req_o  output  1  instruction memory request.
REQ-007 SHALL have imem_addr_o  output  32  fetch address, word aligned.
REQ-008 SHALL have imem_ready_i  input  1  response valid for current request; imem_rdata_i  input  32  instruction word.
REQ-009 SHALL have pc_o  output  32, instr_o  output  32, valid_o  output  1: IF/ID register contents to ID stage.

Function
REQ-010 SHALL define hold = stall_i OR NOT pc_write_i; flush accepted = flush_i AND NOT hold (hold masks flush).
REQ-011 SHALL implement states S_FETCH, S_HOLD, S_DROP.
REQ-012 S_FETCH: imem_req_o=1, imem_addr_o=fetch PC; address SHALL stay stable until imem_ready_i.
REQ-013 S_FETCH, ready=1, no hold, no flush: IF/ID loads {fetch PC, imem_rdata_i, valid=1}, fetch PC += 4 (32-bit wrap, 0xFFFFFFFC -> 0x00000000), stay S_FETCH.
REQ-014 S_FETCH, ready=1, hold: word captured in internal buffer, IF/ID unchanged, fetch PC unchanged, go S_HOLD.
REQ-015 S_FETCH, ready=0, no hold: IF/ID loads bubble (valid_o=0, instr_o=NOP 0x00000013, pc_o unchanged); ready=0 with hold: IF/ID unchanged.
REQ-016 S_HOLD: imem_req_o=0; when hold drops, IF/ID loads buffered word with valid=1, fetch PC += 4, go S_FETCH, one-cycle latency from hold release.
REQ-017 Flush accepted in S_FETCH with ready=1 or in S_HOLD: discard fetched/buffered word, IF/ID loads bubble, fetch PC <= branch_target_i, go S_FETCH.
REQ-018 Flush accepted in S_FETCH with ready=0: IF/ID loads bubble, latch branch_target_i, go S_DROP.
REQ-019 S_DROP: imem_req_o=1 at old address; on ready discard data, fetch PC <= latched target, go S_FETCH; IF/ID stays bubble; later flushes overwrite latched target.
REQ-020 Latency: ready-to-valid_o one cycle; redirect to first target request next cycle (S_FETCH/S_HOLD cases).
REQ-021 Simultaneous flush_i and hold: hold wins, flush ignored that cycle.

Reset
REQ-022 rst_i=1 SHALL set fetch PC=0x00000000, pc_o=0, instr_o=0x00000013, valid_o=0, buffer cleared, state S_FETCH, imem_req_o=0 during reset cycle.
REQ-023 Reset mid-request SHALL abandon the outstanding request; first request at 0x00000000 the cycle after rst_i deasserts; ready during reset ignored.
REQ-024 Reset SHALL override hold and flush.

Structure
REQ-025 Shared package fetch_pkg SHALL hold NOP_INSTR=32'h00000013, RESET_PC=32'h0, PC_STEP=4, and state encoding.
REQ-026 IF/ID register SHALL be sub-module if_id_reg (load, bubble, hold controls); FSM and PC in fetch_stage.

Verification
REQ-027 Reset then ready every cycle with rdata=addr+0x100 -> valid_o=1, pc_o 0,4,8,... instr_o 0x100,0x104,...
REQ-028 Hold (stall_i=1, pc_write_i=0) 2 cycles during ready at PC 0x8 -> IF/ID holds PC 0x4, S_HOLD; release -> pc_o=0x8 next cycle, next request 0xC.
REQ-029 flush_i=1, target 0x40, with ready=1 at PC 0x10 -> valid_o=0, instr_o=0x13, next request 0x40, then pc_o=0x40.
REQ-030 flush_i=1, target 0x80, with ready=0 for 3 cycles -> address held, response discarded, next request 0x80.
REQ-031 flush_i=1 and stall_i=1 together -> flush ignored, IF/ID held, PC unchanged.
REQ-032 rst_i in S_DROP -> outputs to reset values, request at 0x0 after release, latched target lost.
